// File: rtl/down_counter_pkg.sv
// Shared definitions for the down counter: state encoding and default width.
package down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Control state encoding, also reused by the up counter's control FSM and benches
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/down_counter_if.sv
// Control/status bundle of the down counter; master drives controls, slave is the counter.
interface down_counter_if
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic [WIDTH-1:0] cout;
    logic             tc;
    logic             busy;
    logic             zero;

    modport master (
        output enable, load, load_val, auto_reload,
        input  cout, tc, busy, zero
    );

    modport slave (
        input  enable, load, load_val, auto_reload,
        output cout, tc, busy, zero
    );

endinterface

// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-shot or auto-reload mode and a one-cycle tc pulse.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    down_counter_if.slave bus
);

    state_e           state_q;
    logic [WIDTH-1:0] cout_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;

    // Control state, count, reload value and terminal pulse; load wins over enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cout_q   <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.load) begin
                cout_q   <= bus.load_val;
                reload_q <= bus.load_val;
                state_q  <= (bus.load_val != '0) ? ST_RUN : ST_IDLE;
            end else if (state_q == ST_RUN && bus.enable) begin
                if (cout_q == WIDTH'(1)) begin
                    // Terminal event: reload for periodic ticks, otherwise park at zero
                    tc_q <= 1'b1;
                    if (bus.auto_reload) begin
                        cout_q <= reload_q;
                    end else begin
                        cout_q  <= '0;
                        state_q <= ST_DONE;
                    end
                end else begin
                    cout_q <= cout_q - WIDTH'(1);
                end
            end
        end
    end

    // Status outputs
    assign bus.cout = cout_q;
    assign bus.tc   = tc_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.zero = (cout_q == '0);

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down-counter/timer, the counting-down counterpart of the team's 4-bit up counter. It shares that counter's clk/rst/enable/cout port style.
- Software or an FSM loads a start value. The block decrements on enabled cycles and flags terminal count with a one-cycle pulse.
- It can free-run as a periodic tick generator (auto-reload) or stop at zero (one-shot).

Parameters:
- WIDTH, 4, width of count value, load value and reload register (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- enable  input  1  count qualifier; cout decrements only on cycles with enable=1 in RUN.
- load  input  1  one-cycle strobe that captures load_val.
- load_val  input  WIDTH  start and reload value.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode. Sampled on every terminal event.
- cout  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, high for exactly 1 cycle.
- busy  output  1  high while state = RUN.
- zero  output  1  combinational flag, cout == 0.

Behaviour:
- Asynchronous reset (rst=0):
  - cout=0, reload_reg=0, tc=0, state=IDLE, so busy=0 and zero=1.
  - Reset takes effect immediately, mid-count included, with no tc.
  - Release is synchronous in effect: the first active edge after rst rises behaves normally.
- States:
  - IDLE: after reset, or after a load of 0.
  - RUN: counting.
  - DONE: one-shot expired.
- Priority per edge: load > enable. When load=1, enable in the same cycle is ignored (no decrement).
- load=1, any state:
  - cout <= load_val, reload_reg <= load_val, tc <= 0.
  - Next state is RUN if load_val != 0, otherwise IDLE.
- RUN, enable=0: everything holds and tc <= 0.
- RUN, enable=1, cout > 1: cout <= cout - 1, tc <= 0.
- RUN, enable=1, cout == 1 (terminal event): tc <= 1.
  - If auto_reload=1: cout <= reload_reg, stay in RUN. The period is reload_reg enabled cycles per tc.
  - If auto_reload=0: cout <= 0, go to DONE.
- tc is high in the cycle immediately after the terminal edge and drops the next cycle unless another terminal event occurs.
  - With reload_reg=1 and auto_reload=1, tc stays high on every enabled cycle and cout stays at 1.
- DONE: cout holds 0, tc=0, enable is ignored. Only load or reset leaves DONE.
- IDLE: cout holds, enable is ignored.
- No wrap-around:
  - cout never underflows from 0 to all-ones.
  - cout == 0 is never reachable inside RUN.
- Arithmetic: unsigned WIDTH-bit decrement, no carry out.
- Latency:
  - load to cout visible: 1 cycle.
  - Enabled edge at cout==1 to tc high: 1 cycle (registered).

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, for reuse by the up counter's future control FSM and by benches.
  - default WIDTH constant.
- No sub-module. A single always block for state/cout/reload_reg/tc plus continuous assigns for busy and zero.

Test Plan:
1. Reset then load_val=4'd3, auto_reload=0, enable=1 held → cout 3,2,1,0 on successive edges. tc=1 only in the cycle cout first reads 0. busy falls with it; state DONE and zero=1 thereafter, with enable still high.
2. load_val=4'd4, auto_reload=1, enable=1 for 12 cycles → cout 4,3,2,1,4,3,2,1,4,... tc pulses every 4th cycle (3 pulses), cout never 0.
3. load_val=4'd5, enable toggled 1,0,1,0 → cout 5,4,4,3,3. No tc; busy stays 1.
4. Simultaneous events:
   - load=1, enable=1 with load_val=4'd9 while cout=2 → cout=9 next cycle (no decrement, no tc).
   - load_val=0 → cout=0, state IDLE, busy=0, tc=0.
5. Reset mid-count: cout=6 in RUN, pull rst low between edges → cout=0, busy=0, tc=0 immediately (asynchronous). After release, enable=1 gives no counting until the next load.
6. Edge value with WIDTH=4: load_val=4'd15, auto_reload=0 → 15 enabled cycles to tc. load_val=4'd1 with auto_reload=1 → tc high continuously while enable=1, cout stays 1.
